stf_seq: RTL and testbench
==========================

Name: stf_seq

Overview:
- Sequences the 16-entry short-training-field sample ROM to produce the complete 802.11 legacy STF burst at the start of a TX packet.
- On a start pulse, walks ROM addresses 0..15 NUM_REP times and streams one 32-bit I/Q sample per accepted beat on a valid/ready interface.
- Optionally halves the first and last samples as a boundary window.
- Sits between the TX control FSM and the sample mux feeding the IFFT-output/DAC path.

Parameters:
- NUM_REP, 10, number of 16-sample STF periods per burst (160 samples by default); legal range 1..15.
- WINDOW_EN, 1, when 1, the first and last burst samples are scaled by 1/2 (I and Q independently).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to emit one burst; ignored while busy=1.
- abort  in  1  synchronous cancel; takes priority over every other input.
- rom_addr  out  4  address to the combinational STF ROM.
- rom_dout  in  32  ROM data, {I[15:0], Q[15:0]}, two's complement, valid in the same cycle as rom_addr.
- out_data  out  32  sample {I, Q}.
- out_valid  out  1  out_data holds a sample.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_last  out  1  qualifies the final sample of a burst.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses, or until abort.
- done  out  1  one-cycle pulse after the final sample is accepted.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, done=0, idx=0, state=IDLE.
- Sample index idx is 8 bits, range 0..TOTAL-1, where TOTAL=NUM_REP*16.
- rom_addr = idx[3:0], combinational; wrap 15→0 is the natural 4-bit rollover.
- States:
  - IDLE: rom_addr=0. If start & !abort, load sample 0 into the output register, set out_valid=1 and busy=1, set idx=1, go to RUN. First out_valid is the cycle after start.
  - RUN: load enable = !out_valid | out_ready (holding register, no bubble under continuous ready). On load, out_data is the windowed rom_dout, out_last=(idx==TOTAL-1), idx increments. After loading idx=TOTAL-1, go to LAST.
  - LAST: hold the output until out_valid & out_ready. Then clear out_valid and out_last, pulse done=1 for one cycle, busy=0, idx=0, go to IDLE.
- Throughput: with out_ready tied high, exactly TOTAL consecutive valid cycles. done asserts at cycle start+TOTAL+1.
- Backpressure: out_data, out_last and idx are frozen while out_valid & !out_ready. No sample is skipped or duplicated.
- Windowing: applies when WINDOW_EN=1 and idx is 0 or TOTAL-1.
  - I'=I>>>1 and Q'=Q>>>1 (arithmetic shift, truncation toward -inf), each 16-bit, no saturation needed.
  - If TOTAL=16, samples 0 and 15 are both windowed.
- abort: in any state, on the next edge out_valid=0, out_last=0, busy=0, idx=0, state=IDLE, and no done pulse. abort with start in the same cycle means no burst starts.
- start asserted in RUN or LAST is ignored; it is not queued.
- done and a new start in the same cycle: start is accepted only in IDLE, i.e. the cycle after done at the earliest.
- Asynchronous reset mid-burst returns everything to the reset values immediately. There is no partial-burst recovery.

Decomposition:
- Shared tx package holds:
  - STF_LEN=16
  - sample typedef (32-bit {I,Q})
  - state enum {IDLE, RUN, LAST}
  - a halve_iq function used by the window logic (reusable by the LTF sequencer)
- No sub-module is needed. The ROM stays external and is instantiated by the parent next to this block, so the same controller can later drive the LTF ROM via a parameterised period length.

Test Plan:
- Reset, then start with out_ready=1 and WINDOW_EN=1:
  - out_valid first high 1 cycle after start; exactly 160 valid beats.
  - beat 0 = 0xfe87fe87 (from 0xfd0efd0e).
  - beat 1 = 0xfe6803d9; beat 16 = 0xfd0efd0e unwindowed.
  - beat 159 = 0x01ecff34 with out_last=1.
  - done 1 cycle after beat 159; busy low the same cycle.
- Random out_ready (≈50%): the 160 accepted samples equal the ROM sequence {addr 0..15}×10 in order, with no duplicates or gaps; out_data is stable while stalled.
- abort at beat 73 while stalled: the next cycle has out_valid=0 and busy=0, and done never pulses. A subsequent start restarts from beat 0 = 0xfe87fe87.
- start pulsed during RUN and in the done cycle: ignored, and exactly 160 beats are produced. A start one cycle after done produces a second full burst.
- NUM_REP=1, WINDOW_EN=0: 16 beats, beat 0 = 0xfd0efd0e, beat 15 = 0x03d9fe68 with out_last=1, then done.
- Assert rstn=0 mid-burst: all outputs are 0 asynchronously. After release, idle with no spurious done.

Source files
------------

// File: rtl/stf_seq_pkg.sv
// Shared TX definitions for the training-field sequencers.
package stf_seq_pkg;

    localparam int STF_LEN = 16;

    // One I/Q sample, {I[15:0], Q[15:0]}, two's complement.
    typedef logic [31:0] sample_t;

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    // Halve I and Q independently with an arithmetic shift (rounds toward -inf).
    function automatic sample_t halve_iq(input sample_t s);
        logic signed [15:0] i_s;
        logic signed [15:0] q_s;
        i_s = s[31:16];
        q_s = s[15:0];
        i_s = i_s >>> 1;
        q_s = q_s >>> 1;
        return {i_s, q_s};
    endfunction

endpackage

// File: rtl/stf_seq.sv
// STF burst sequencer: walks the external 16-entry ROM NUM_REP times and
// streams the samples on a valid/ready port, optionally halving the first
// and last sample of the burst.
module stf_seq #(
    parameter int NUM_REP   = 10,
    parameter bit WINDOW_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_dout,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);
    import stf_seq_pkg::*;

    localparam int             TOTAL    = NUM_REP * STF_LEN;
    localparam logic [7:0]     LAST_IDX = 8'(TOTAL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] idx;
    logic       load;
    logic       finish;
    logic       clear;
    logic       at_edge;
    sample_t    win_data;

    // idx is held at 0 outside a burst, so the ROM sees address 0 while idle.
    assign rom_addr = idx[3:0];
    assign at_edge  = (idx == 8'd0) || (idx == LAST_IDX);
    assign win_data = (WINDOW_EN && at_edge) ? halve_iq(rom_dout) : rom_dout;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus the load / finish / clear strobes for the datapath.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        clear     = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            clear     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // The done cycle is already IDLE; a start there is dropped.
                    if (start && !done) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    // Holding register: refill when empty or being drained.
                    if (!out_valid || out_ready) begin
                        load = 1'b1;
                        if (idx == LAST_IDX) state_nxt = LAST;
                    end
                end
                LAST: begin
                    if (out_valid && out_ready) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output register, sample index and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            idx       <= 8'd0;
        end else begin
            done <= finish;
            if (clear) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                idx       <= 8'd0;
            end else if (load) begin
                out_data  <= win_data;
                out_valid <= 1'b1;
                out_last  <= (idx == LAST_IDX);
                busy      <= 1'b1;
                idx       <= idx + 8'd1;
            end else if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                idx       <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_stf_seq.sv
// Bench for stf_seq: a default instance (10 reps, windowed) and a short
// instance (1 rep, no window) share one ROM image and one handshake.
module tb_stf_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic [3:0]  d0_addr, d1_addr;
    logic [31:0] d0_rom, d1_rom, d0_data, d1_data;
    logic        d0_valid, d1_valid, d0_last, d1_last;
    logic        d0_busy, d1_busy, d0_done, d1_done;

    logic [31:0] rom [16];

    int ncmp = 0;
    int nerr = 0;

    bit          sel = 1'b0;
    logic [31:0] m_data;
    logic        m_valid, m_last, m_busy, m_done;
    logic [31:0] got [$];

    always #5 clk = ~clk;

    assign d0_rom = rom[d0_addr];
    assign d1_rom = rom[d1_addr];

    assign m_data  = sel ? d1_data  : d0_data;
    assign m_valid = sel ? d1_valid : d0_valid;
    assign m_last  = sel ? d1_last  : d0_last;
    assign m_busy  = sel ? d1_busy  : d0_busy;
    assign m_done  = sel ? d1_done  : d0_done;

    stf_seq #(.NUM_REP(10), .WINDOW_EN(1'b1)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .abort(abort),
        .rom_addr(d0_addr), .rom_dout(d0_rom), .out_data(d0_data),
        .out_valid(d0_valid), .out_ready(out_ready), .out_last(d0_last),
        .busy(d0_busy), .done(d0_done)
    );

    stf_seq #(.NUM_REP(1), .WINDOW_EN(1'b0)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .abort(abort),
        .rom_addr(d1_addr), .rom_dout(d1_rom), .out_data(d1_data),
        .out_valid(d1_valid), .out_ready(out_ready), .out_last(d1_last),
        .busy(d1_busy), .done(d1_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Floor division by two on a signed 16-bit value.
    function automatic logic [15:0] half16(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        v = (v < 0) ? -((1 - v) / 2) : v / 2;
        return 16'(v);
    endfunction

    task automatic set_start(input bit v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Runs one burst from a negedge with the selected DUT idle. Returns at the
    // negedge one cycle after done (or some cycles after an abort).
    task automatic run_burst(input int total, input bit win, input int pct,
                             input int abort_at, input bit poke);
        logic [31:0] expq [$];
        logic [31:0] w, pd;
        logic        pl;
        int          n, cyc;
        bit          stalled, aborted;
        for (int k = 0; k < total; k++) begin
            w = rom[k % 16];
            if (win && (k == 0 || k == total - 1)) w = {half16(w[31:16]), half16(w[15:0])};
            expq.push_back(w);
        end
        got.delete();
        chk("idle_busy", {31'd0, m_busy}, 32'd0);
        set_start(1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        set_start(1'b0);
        chk("first_valid", {31'd0, m_valid}, 32'd1);
        chk("first_busy", {31'd0, m_busy}, 32'd1);
        n = 0; cyc = 0; stalled = 0; aborted = 0; pd = '0; pl = 1'b0;
        while (n < total && cyc < 4000 && !aborted) begin
            chk("valid_run", {31'd0, m_valid}, 32'd1);
            chk("done_mid", {31'd0, m_done}, 32'd0);
            if (stalled) begin
                chk("stall_data", m_data, pd);
                chk("stall_last", {31'd0, m_last}, {31'd0, pl});
            end
            out_ready = ($urandom_range(0, 99) < pct);
            if (n == abort_at) begin
                out_ready = 1'b0;
                abort = 1'b1;
            end
            if (poke && n == 40) set_start(1'b1);
            if (m_valid && out_ready) begin
                chk($sformatf("beat%0d", n), m_data, expq[n]);
                chk($sformatf("last%0d", n), {31'd0, m_last}, {31'd0, n == total - 1});
                got.push_back(m_data);
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                pd = m_data;
                pl = m_last;
            end
            @(negedge clk);
            set_start(1'b0);
            if (abort) begin
                abort = 1'b0;
                chk("abort_valid", {31'd0, m_valid}, 32'd0);
                chk("abort_busy", {31'd0, m_busy}, 32'd0);
                aborted = 1;
            end
            cyc++;
        end
        if (aborted) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                chk("abort_no_done", {29'd0, m_done, m_valid, m_busy}, 32'd0);
            end
        end else begin
            chk("beat_count", n, total);
            chk("done_pulse", {31'd0, m_done}, 32'd1);
            chk("done_busy", {31'd0, m_busy}, 32'd0);
            chk("done_valid", {31'd0, m_valid}, 32'd0);
            set_start(poke);
            @(negedge clk);
            set_start(1'b0);
            chk("post_done", {29'd0, m_done, m_valid, m_busy}, 32'd0);
        end
    endtask

    initial begin
        rom[0]  = 32'hfd0efd0e;
        rom[1]  = 32'hfe6803d9;
        rom[15] = 32'h03d9fe68;
        for (int k = 2; k < 15; k++) rom[k] = $urandom;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_data", d0_data, 32'd0);
        chk("rst_flags", {28'd0, d0_valid, d0_last, d0_busy, d0_done}, 32'd0);
        chk("rst_addr", {28'd0, d0_addr}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Full-rate windowed burst with directed beat values.
        sel = 1'b0;
        run_burst(160, 1'b1, 100, -1, 1'b0);
        if (got.size() == 160) begin
            chk("beat0_const", got[0], 32'hfe87fe87);
            chk("beat1_const", got[1], 32'hfe6803d9);
            chk("beat16_const", got[16], 32'hfd0efd0e);
            chk("beat159_const", got[159], 32'h01ecff34);
        end else begin
            chk("burst1_size", got.size(), 160);
        end

        // Random backpressure.
        run_burst(160, 1'b1, 50, -1, 1'b0);
        run_burst(160, 1'b1, 30, -1, 1'b0);

        // Abort while stalled at beat 73, then a clean restart.
        run_burst(160, 1'b1, 50, 73, 1'b0);
        run_burst(160, 1'b1, 100, -1, 1'b0);
        if (got.size() > 0) chk("restart_beat0", got[0], 32'hfe87fe87);
        else                chk("restart_size", got.size(), 160);

        // Start and abort in the same cycle: nothing starts.
        start0 = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort = 1'b0;
        chk("start_abort", {30'd0, d0_valid, d0_busy}, 32'd0);

        // Starts during RUN and in the done cycle are ignored; the next burst
        // is launched one cycle after done.
        run_burst(160, 1'b1, 70, -1, 1'b1);
        run_burst(160, 1'b1, 100, -1, 1'b0);

        // Single-period, unwindowed instance.
        sel = 1'b1;
        run_burst(16, 1'b0, 100, -1, 1'b0);
        if (got.size() == 16) begin
            chk("short_beat0", got[0], 32'hfd0efd0e);
            chk("short_beat15", got[15], 32'h03d9fe68);
        end else begin
            chk("short_size", got.size(), 16);
        end
        run_burst(16, 1'b0, 50, -1, 1'b0);

        // Asynchronous reset in mid-burst.
        sel = 1'b0;
        out_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (30) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_data", d0_data, 32'd0);
        chk("arst_flags", {28'd0, d0_valid, d0_last, d0_busy, d0_done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("arst_idle", {29'd0, d0_done, d0_valid, d0_busy}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
